// File: rtl/board_row_fetch_arbiter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tetris_pkg
// Brief    : Shared types and board geometry for the board row fetch arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package tetris_pkg;

    typedef logic [15:0] cell_t;

    localparam int BOARD_W     = 10;
    localparam int BOARD_H     = 20;
    localparam int CELL_ADDR_W = 8;
    localparam int COL_W       = $clog2(BOARD_W);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GL    = 3'd1,
        FETCH = 3'd2,
        DRAIN = 3'd3,
        SWAP  = 3'd4
    } fetch_state_t;

    function automatic logic [CELL_ADDR_W-1:0] cell_addr(
        input logic [CELL_ADDR_W-1:0] row,
        input logic [COL_W-1:0]       col
    );
        return CELL_ADDR_W'(row * CELL_ADDR_W'(BOARD_W)) + CELL_ADDR_W'(col);
    endfunction

endpackage
`default_nettype wire

// File: rtl/board_row_fetch_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : board_row_fetch_arbiter_if
// Brief    : Board RAM port plus game-logic single-cell access handshake.
// Revision : 1.0 - initial release
// ============================================================================
interface board_row_fetch_arbiter_if;
    import tetris_pkg::*;

    logic [CELL_ADDR_W-1:0] ram_addr;
    logic                   ram_we;
    cell_t                  ram_wdata;
    cell_t                  ram_rdata;

    logic                   gl_req;
    logic                   gl_we;
    logic [CELL_ADDR_W-1:0] gl_addr;
    cell_t                  gl_wdata;
    logic                   gl_gnt;
    logic                   gl_rvalid;
    cell_t                  gl_rdata;

    modport master (
        output ram_addr, ram_we, ram_wdata, gl_gnt, gl_rvalid, gl_rdata,
        input  ram_rdata, gl_req, gl_we, gl_addr, gl_wdata
    );

    modport slave (
        input  ram_addr, ram_we, ram_wdata, gl_gnt, gl_rvalid, gl_rdata,
        output ram_rdata, gl_req, gl_we, gl_addr, gl_wdata
    );
endinterface
`default_nettype wire

// File: rtl/board_row_fetch_arbiter_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : board_row_buffer
// Brief    : Back/front row registers; back fills per column, front updates
//            only on the swap strobe.
// Revision : 1.0 - initial release
// ============================================================================
module board_row_buffer
    import tetris_pkg::*;
(
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_wr_en,
    input  wire logic [COL_W-1:0] i_wr_col,
    input  wire cell_t            i_wr_data,
    input  wire logic             i_swap,
    output cell_t                 o_row [BOARD_W]
);

    cell_t r_back  [BOARD_W];
    cell_t r_front [BOARD_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BOARD_W; i++) begin
                r_back[i]  <= '0;
                r_front[i] <= '0;
            end
        end else begin
            for (int i = 0; i < BOARD_W; i++) begin
                if (i_wr_en && (i_wr_col == COL_W'(i))) begin
                    r_back[i] <= i_wr_data;
                end
                if (i_swap) begin
                    r_front[i] <= r_back[i];
                end
            end
        end
    end

    assign o_row = r_front;

endmodule
`default_nettype wire

// File: rtl/board_row_fetch_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : board_row_fetch_arbiter
// Brief    : Shares the board RAM port between display row prefetch (priority)
//            and game-logic cell access. Optional: FETCH_OVERRUN_DET_EN.
// Revision : 1.0 - initial release
// ============================================================================
module board_row_fetch_arbiter
    import tetris_pkg::*;
#(
    parameter int SQUARE_SIZE = 21,
    parameter int V_LAST      = 479
)(
    input  wire logic                   Clk,
    input  wire logic                   reset_n,
    input  wire logic                   hblank,
    input  wire logic [9:0]             DrawY,
    board_row_fetch_arbiter_if.master   bus,
    output cell_t                       Row [BOARD_W],
    output logic [CELL_ADDR_W-1:0]      rowNum,
    output logic                        rowReady
`ifdef FETCH_OVERRUN_DET_EN
    ,
    output logic                        fetch_overrun
`endif
);

    fetch_state_t           r_state;
    fetch_state_t           w_next;
    logic                   r_hblank_d;
    logic                   r_pend;
    logic [CELL_ADDR_W-1:0] r_pend_row;
    logic [CELL_ADDR_W-1:0] r_cur_row;
    logic [COL_W-1:0]       r_col;
    logic                   r_wr_en;
    logic [COL_W-1:0]       r_wr_col;
    logic                   r_gl_rd;

    logic                   w_rise;
    logic [10:0]            w_y1;
    logic [10:0]            w_band_row;
    logic [10:0]            w_band_mod;
    logic                   w_last_hit;
    logic                   w_trigger;
    logic [CELL_ADDR_W-1:0] w_trig_row;
    logic                   w_start_fetch;
    logic                   w_gnt;
    logic                   w_we;
    logic [CELL_ADDR_W-1:0] w_addr;
    cell_t                  w_wdata;

    // Block-row boundary: the line after this one starts a new block row.
    assign w_rise     = hblank & ~r_hblank_d;
    assign w_y1       = {1'b0, DrawY} + 11'd1;
    assign w_band_row = w_y1 / 11'(SQUARE_SIZE);
    assign w_band_mod = w_y1 % 11'(SQUARE_SIZE);
    assign w_last_hit = (DrawY == 10'(V_LAST));
    assign w_trigger  = w_rise && (w_last_hit ||
                        ((w_band_mod == 11'd0) && (w_band_row < 11'(BOARD_H))));
    assign w_trig_row = w_last_hit ? '0 : CELL_ADDR_W'(w_band_row);

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_start_fetch = 1'b0;
        w_gnt         = 1'b0;
        w_we          = 1'b0;
        w_addr        = '0;
        w_wdata       = '0;
        case (r_state)
            IDLE: begin
                // A trigger seen this cycle blocks the grant so fetch wins.
                if (r_pend) begin
                    w_next        = FETCH;
                    w_start_fetch = 1'b1;
                end else if (bus.gl_req && !w_trigger) begin
                    w_next = GL;
                end
            end
            GL: begin
                w_gnt   = 1'b1;
                w_we    = bus.gl_we;
                w_addr  = bus.gl_addr;
                w_wdata = bus.gl_wdata;
                w_next  = IDLE;
            end
            FETCH: begin
                w_addr = cell_addr(r_cur_row, r_col);
                if (r_col == COL_W'(BOARD_W - 1)) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                w_next = SWAP;
            end
            SWAP: begin
                w_next = (!r_pend && !w_trigger && bus.gl_req) ? GL : IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hblank_d <= 1'b0;
            r_pend     <= 1'b0;
            r_pend_row <= '0;
            r_cur_row  <= '0;
            r_col      <= '0;
            r_wr_en    <= 1'b0;
            r_wr_col   <= '0;
            r_gl_rd    <= 1'b0;
            rowNum     <= '0;
            rowReady   <= 1'b0;
        end else begin
            r_hblank_d <= hblank;
            // A new trigger re-arms the request even while a fetch is running.
            if (w_trigger) begin
                r_pend     <= 1'b1;
                r_pend_row <= w_trig_row;
            end else if (w_start_fetch) begin
                r_pend <= 1'b0;
            end
            if (w_start_fetch) begin
                r_cur_row <= r_pend_row;
            end
            r_col    <= ((r_state == FETCH) && (w_next == FETCH)) ? r_col + COL_W'(1) : '0;
            r_wr_en  <= (r_state == FETCH);
            r_wr_col <= r_col;
            r_gl_rd  <= (r_state == GL) && !bus.gl_we;
            rowReady <= (r_state == SWAP);
            if (r_state == SWAP) begin
                rowNum <= r_cur_row;
            end
        end
    end

    board_row_buffer u_row_buffer (
        .clk       (Clk),
        .rst_n     (reset_n),
        .i_wr_en   (r_wr_en),
        .i_wr_col  (r_wr_col),
        .i_wr_data (bus.ram_rdata),
        .i_swap    (r_state == SWAP),
        .o_row     (Row)
    );

    assign bus.ram_addr  = w_addr;
    assign bus.ram_we    = w_we;
    assign bus.ram_wdata = w_wdata;
    assign bus.gl_gnt    = w_gnt;
    assign bus.gl_rvalid = r_gl_rd;
    assign bus.gl_rdata  = r_gl_rd ? bus.ram_rdata : '0;

`ifdef FETCH_OVERRUN_DET_EN
    logic r_overrun;

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overrun <= 1'b0;
        end else if (!hblank && r_hblank_d &&
                     (r_pend || (r_state == FETCH) || (r_state == DRAIN) || (r_state == SWAP))) begin
            r_overrun <= 1'b1;
        end
    end

    assign fetch_overrun = r_overrun;
`endif

endmodule
`default_nettype wire
